// File: rtl/array_xfrm_pkg.sv
// array_xfrm_pkg: FSM state type, cfg_mode bit positions and the wrap-around element transform.
// Latency: none, declarations only.
// Backpressure: not applicable.
package array_xfrm_pkg;

   typedef enum logic {
      LOAD = 1'b0,
      EMIT = 1'b1
   } state_t;

   // Bit positions inside cfg_mode
   localparam int MODE_SUB = 0;
   localparam int MODE_REV = 1;

   // Transform is computed at a fixed wide width. The caller truncates the
   // result to WIDTH, which gives the same answer as modulo-2^WIDTH arithmetic.
   localparam int XFRM_W = 64;

   function automatic logic [XFRM_W-1:0] xfrm(
      input logic [XFRM_W-1:0] elem,
      input logic [XFRM_W-1:0] k,
      input logic              sub
   );
      return sub ? (elem - k) : (elem + k);
   endfunction

endpackage

// File: rtl/array_xfrm_if.sv
// array_xfrm_if: bundles the configuration, input stream, output stream and status of array_xfrm.
// Latency: none, wiring only.
// Backpressure: in_valid/in_ready on the input side, out_valid/out_ready on the output side.
// Ports: master = producer/consumer side (drives cfg_*, in_valid, in_data, out_ready);
//        slave  = engine side (drives in_ready, out_*, busy, bursts_done).
interface array_xfrm_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 5,
   parameter int CNT_W = 16
);
   localparam int IDX_W = $clog2(DEPTH);

   logic [1:0]       cfg_mode;
   logic [WIDTH-1:0] cfg_k;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [IDX_W-1:0] out_idx;
   logic             out_last;
   logic             busy;
   logic [CNT_W-1:0] bursts_done;

   modport master (
      output cfg_mode, cfg_k, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_idx, out_last, busy, bursts_done
   );

   modport slave (
      input  cfg_mode, cfg_k, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_idx, out_last, busy, bursts_done
   );

endinterface

// File: rtl/array_xfrm_buf.sv
// array_xfrm_buf: DEPTH x WIDTH register file holding one burst.
// Latency: write lands on the next rising edge; read is combinational from the stored contents.
// Backpressure: none, the caller gates wr_en.
// Ports: clk, wr_en/wr_addr/wr_data (synchronous write), rd_addr -> rd_data (asynchronous read).
module array_xfrm_buf #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 5
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]         rd_data
);

   // Contents are left unreset: every entry is rewritten before it can be read.
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/array_xfrm.sv
// array_xfrm: buffers a DEPTH-element burst, then streams each element +/- k in forward or reversed order.
// Latency: out_valid rises the cycle after the last input handshake; in_ready returns the cycle after out_last is taken.
// Backpressure: out_ready low holds out_data, out_idx and out_last; in_ready is low for the whole EMIT phase.
// Ports: clk, rst_n (synchronous, active low), bus (array_xfrm_if.slave).
module array_xfrm
   import array_xfrm_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 5,
   parameter int CNT_W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   array_xfrm_if.slave  bus
);

   localparam int               IDX_W = $clog2(DEPTH);
   localparam logic [IDX_W-1:0] LAST  = IDX_W'(DEPTH - 1);

   state_t           state;
   logic [IDX_W-1:0] wr_cnt;
   logic [IDX_W-1:0] rd_cnt;
   logic [IDX_W-1:0] rd_nxt;
   logic [1:0]       mode_cap;
   logic [WIDTH-1:0] k_cap;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             out_last_q;
   logic [IDX_W-1:0] out_idx_q;
   logic [CNT_W-1:0] bursts_q;
   logic [WIDTH-1:0] rd_data;
   logic             wr_en;

   assign wr_en  = bus.in_valid && in_ready_q;
   assign rd_nxt = rd_cnt + 1'b1;

   array_xfrm_buf #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_buf (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_cnt),
      .wr_data (bus.in_data),
      .rd_addr (out_idx_q),
      .rd_data (rd_data)
   );

   // out_idx is registered one step ahead, so the buffer read address is
   // already the element being presented; no input reaches the outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= LOAD;
         wr_cnt      <= '0;
         rd_cnt      <= '0;
         mode_cap    <= '0;
         k_cap       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_idx_q   <= '0;
         bursts_q    <= '0;
      end else begin
         case (state)
            LOAD: begin
               if (bus.in_valid) begin
                  // Configuration is frozen for the burst at its first element.
                  if (wr_cnt == '0) begin
                     mode_cap <= bus.cfg_mode;
                     k_cap    <= bus.cfg_k;
                  end
                  if (wr_cnt == LAST) begin
                     // DEPTH >= 2, so mode_cap already holds this burst's mode.
                     wr_cnt      <= '0;
                     rd_cnt      <= '0;
                     state       <= EMIT;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                     out_last_q  <= 1'b0;
                     out_idx_q   <= mode_cap[MODE_REV] ? LAST : '0;
                  end else begin
                     wr_cnt <= wr_cnt + 1'b1;
                  end
               end
            end
            EMIT: begin
               if (bus.out_ready) begin
                  if (out_last_q) begin
                     rd_cnt      <= '0;
                     state       <= LOAD;
                     in_ready_q  <= 1'b1;
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     out_idx_q   <= '0;
                     bursts_q    <= bursts_q + 1'b1;
                  end else begin
                     rd_cnt     <= rd_nxt;
                     out_last_q <= (rd_nxt == LAST);
                     out_idx_q  <= mode_cap[MODE_REV] ? (LAST - rd_nxt) : rd_nxt;
                  end
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_last    = out_last_q;
   assign bus.out_idx     = out_idx_q;
   assign bus.bursts_done = bursts_q;
   assign bus.busy        = (state == EMIT) || (wr_cnt != '0);

   // Forced to zero outside EMIT so stale or unwritten buffer data never shows.
   assign bus.out_data = out_valid_q
                         ? WIDTH'(xfrm(XFRM_W'(rd_data), XFRM_W'(k_cap), mode_cap[MODE_SUB]))
                         : '0;

endmodule

// File: tb/tb_array_xfrm.sv
// tb_array_xfrm: directed bench for array_xfrm at WIDTH=8, DEPTH=5 with hand-computed expected values.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
// Ends with one summary line of error and check counts.
module tb_array_xfrm;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   array_xfrm_if #(.WIDTH(8), .DEPTH(5), .CNT_W(16)) bus ();

   array_xfrm #(
      .WIDTH (8),
      .DEPTH (5),
      .CNT_W (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef logic [7:0] vec_t  [5];
   typedef logic [2:0] ivec_t [5];

   vec_t  din;
   vec_t  exp_d;
   ivec_t exp_i;
   ivec_t idx_fwd;
   ivec_t idx_rev;
   int    n_chk = 0;
   int    n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   // Drives n elements of din, one per cycle. cfg_k switches to k_late from
   // element 2 on, which the engine must ignore.
   task automatic load(input int n, input logic [1:0] mode, input logic [7:0] k,
                       input logic [7:0] k_late);
      for (int i = 0; i < n; i++) begin
         check($sformatf("load%0d in_ready", i), bus.in_ready, 1);
         check($sformatf("load%0d busy", i), bus.busy, (i != 0));
         bus.in_valid = 1'b1;
         bus.in_data  = din[i];
         bus.cfg_mode = mode;
         bus.cfg_k    = (i >= 2) ? k_late : k;
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
   endtask

   task automatic elem_chk(input string tag, input int i);
      check($sformatf("%s e%0d valid", tag, i), bus.out_valid, 1);
      check($sformatf("%s e%0d data", tag, i), bus.out_data, exp_d[i]);
      check($sformatf("%s e%0d idx", tag, i), bus.out_idx, exp_i[i]);
      check($sformatf("%s e%0d last", tag, i), bus.out_last, (i == 4));
      check($sformatf("%s e%0d in_ready", tag, i), bus.in_ready, 0);
      check($sformatf("%s e%0d busy", tag, i), bus.busy, 1);
   endtask

   // Consumes one output burst. With stall set, out_ready follows 1,0,0,1,0,0,1...
   task automatic drain(input string tag, input bit stall);
      for (int i = 0; i < 5; i++) begin
         elem_chk(tag, i);
         if (stall && i > 0) begin
            bus.out_ready = 1'b0;
            repeat (2) begin
               @(negedge clk);
               elem_chk({tag, " hold"}, i);
            end
         end
         bus.out_ready = 1'b1;
         @(negedge clk);
      end
      check({tag, " post in_ready"}, bus.in_ready, 1);
      check({tag, " post valid"}, bus.out_valid, 0);
      check({tag, " post last"}, bus.out_last, 0);
      check({tag, " post busy"}, bus.busy, 0);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      idx_fwd       = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
      idx_rev       = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
      bus.cfg_mode  = 2'b00;
      bus.cfg_k     = '0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      rst_n         = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      check("rst in_ready", bus.in_ready, 1);
      check("rst out_valid", bus.out_valid, 0);
      check("rst out_last", bus.out_last, 0);
      check("rst out_idx", bus.out_idx, 0);
      check("rst out_data", bus.out_data, 0);
      check("rst busy", bus.busy, 0);
      check("rst bursts", bus.bursts_done, 0);

      // Plain add, forward
      din   = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
      exp_d = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
      exp_i = idx_fwd;
      load(5, 2'b00, 8'd1, 8'd1);
      drain("add", 1'b0);
      check("add bursts", bus.bursts_done, 1);

      // Wrap on add
      din   = '{8'd255, 8'd0, 8'd10, 8'd128, 8'd254};
      exp_d = '{8'd0, 8'd1, 8'd11, 8'd129, 8'd255};
      load(5, 2'b00, 8'd1, 8'd1);
      drain("wrapadd", 1'b0);
      check("wrapadd bursts", bus.bursts_done, 2);

      // Wrap on subtract
      exp_d = '{8'd254, 8'd255, 8'd9, 8'd127, 8'd253};
      load(5, 2'b01, 8'd1, 8'd1);
      drain("sub", 1'b0);
      check("sub bursts", bus.bursts_done, 3);

      // Reversed order
      din   = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
      exp_d = '{8'd6, 8'd5, 8'd4, 8'd3, 8'd2};
      exp_i = idx_rev;
      load(5, 2'b10, 8'd1, 8'd1);
      drain("rev", 1'b0);
      check("rev bursts", bus.bursts_done, 4);

      // Output stalls
      exp_d = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
      exp_i = idx_fwd;
      load(5, 2'b00, 8'd1, 8'd1);
      drain("stall", 1'b1);
      check("stall bursts", bus.bursts_done, 5);

      // Mid-burst cfg_k change ignored, then a back-to-back burst at k=7
      pulse_reset();
      check("cfg rst bursts", bus.bursts_done, 0);
      load(5, 2'b00, 8'd1, 8'd7);
      drain("cfgk1", 1'b0);
      check("cfgk1 bursts", bus.bursts_done, 1);
      exp_d = '{8'd8, 8'd9, 8'd10, 8'd11, 8'd12};
      load(5, 2'b00, 8'd7, 8'd7);
      drain("cfgk7", 1'b0);
      check("cfgk7 bursts", bus.bursts_done, 2);

      // Reset during LOAD discards the partial burst
      din = '{8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
      load(3, 2'b10, 8'd3, 8'd3);
      pulse_reset();
      check("rstload busy", bus.busy, 0);
      check("rstload in_ready", bus.in_ready, 1);
      check("rstload bursts", bus.bursts_done, 0);
      din   = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5};
      exp_d = '{8'd10, 8'd9, 8'd8, 8'd7, 8'd6};
      exp_i = idx_fwd;
      load(5, 2'b00, 8'd1, 8'd1);
      drain("afterrst", 1'b0);
      check("afterrst bursts", bus.bursts_done, 1);

      // Reset during EMIT drops out_valid on the next cycle
      load(5, 2'b00, 8'd1, 8'd1);
      check("rstemit pre valid", bus.out_valid, 1);
      bus.out_ready = 1'b0;
      pulse_reset();
      check("rstemit valid", bus.out_valid, 0);
      check("rstemit in_ready", bus.in_ready, 1);
      check("rstemit busy", bus.busy, 0);
      check("rstemit data", bus.out_data, 0);
      check("rstemit bursts", bus.bursts_done, 0);
      bus.out_ready = 1'b1;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
